// File: rtl/axis_arb_pkg.sv
// Shared types and helpers for the packet-level AXI-Stream round-robin arbiter.
package axis_arb_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } arb_state_t;

  // Index width for n sources; never narrower than one bit.
  function automatic int id_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/axis_rr_pick.sv
// Combinational round-robin picker: first requester after `last`, wrapping modulo NUM_INPUTS.
module axis_rr_pick
  import axis_arb_pkg::*;
#(
  parameter  int NUM_INPUTS = 4,
  localparam int ID_W       = id_width(NUM_INPUTS)
) (
  input  logic [NUM_INPUTS-1:0] req,
  input  logic [ID_W-1:0]       last,
  output logic [ID_W-1:0]       gnt_idx,
  output logic                  any
);

  logic [ID_W-1:0] idx;

  always_comb begin
    // NOTE: every output gets a default before the search loop so no path leaves it unassigned (no latch).
    gnt_idx = '0;
    any     = 1'b0;
    idx     = '0;
    // Candidate k=NUM_INPUTS is `last` itself, so a lone repeat requester still wins.
    for (int k = 1; k <= NUM_INPUTS; k++) begin
      idx = ID_W'((int'(last) + k) % NUM_INPUTS);
      if (!any && req[idx]) begin
        any     = 1'b1;
        gnt_idx = idx;
      end
    end
  end

endmodule

// File: rtl/axis_rr_arbiter.sv
// Packet-level round-robin AXI-Stream arbiter: N slave inputs onto one registered master output.
module axis_rr_arbiter
  import axis_arb_pkg::*;
#(
  parameter  int NUM_INPUTS  = 4,
  parameter  int TDATA_BYTES = 1,
  localparam int ID_W        = id_width(NUM_INPUTS),
  localparam int DATA_W      = TDATA_BYTES * 8
) (
  input  logic                         aclk,
  input  logic                         aresetn,
  input  logic [NUM_INPUTS*DATA_W-1:0] s_tdata,
  input  logic [NUM_INPUTS-1:0]        s_tvalid,
  input  logic [NUM_INPUTS-1:0]        s_tlast,
  output logic [NUM_INPUTS-1:0]        s_tready,
  output logic [DATA_W-1:0]            m_tdata,
  output logic                         m_tvalid,
  output logic                         m_tlast,
  output logic [ID_W-1:0]              m_tid,
  input  logic                         m_tready
);

  arb_state_t      state, state_next;
  logic [ID_W-1:0] grant, grant_next;
  logic [ID_W-1:0] last_grant, last_grant_next;
  logic [ID_W-1:0] pick_idx;
  logic            pick_any;
  logic            out_free;
  logic            accept;

  logic [DATA_W-1:0] s_slice [NUM_INPUTS];

  for (genvar i = 0; i < NUM_INPUTS; i++) begin : g_slice
    assign s_slice[i] = s_tdata[i*DATA_W +: DATA_W];
  end

  axis_rr_pick #(
    .NUM_INPUTS (NUM_INPUTS)
  ) u_pick (
    .req     (s_tvalid),
    .last    (last_grant),
    .gnt_idx (pick_idx),
    .any     (pick_any)
  );

  // The output register can take a new beat when empty or draining this cycle.
  assign out_free = !m_tvalid || m_tready;

  always_comb begin
    state_next      = state;
    grant_next      = grant;
    last_grant_next = last_grant;
    s_tready        = '0;
    accept          = 1'b0;
    case (state)
      IDLE: begin
        if (pick_any) begin
          grant_next = pick_idx;
          state_next = BUSY;
        end
      end
      BUSY: begin
        // The grant is held through tvalid gaps; only tlast releases it.
        s_tready[grant] = out_free;
        accept          = s_tvalid[grant] && out_free;
        if (accept && s_tlast[grant]) begin
          last_grant_next = grant;
          state_next      = IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    if (!aresetn) begin
      state      <= IDLE;
      grant      <= '0;
      last_grant <= ID_W'(NUM_INPUTS - 1);
    end else begin
      state      <= state_next;
      grant      <= grant_next;
      last_grant <= last_grant_next;
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      m_tvalid <= 1'b0;
      m_tdata  <= '0;
      m_tlast  <= 1'b0;
      m_tid    <= '0;
    end else if (accept) begin
      m_tvalid <= 1'b1;
      m_tdata  <= s_slice[grant];
      m_tlast  <= s_tlast[grant];
      m_tid    <= grant;
    end else if (m_tready) begin
      m_tvalid <= 1'b0;
    end
  end

  a_single_ready: assert property (@(posedge aclk) disable iff (!aresetn)
    $onehot0(s_tready));

  a_hold_stable: assert property (@(posedge aclk) disable iff (!aresetn)
    m_tvalid && !m_tready |=> m_tvalid && $stable({m_tdata, m_tlast, m_tid}));

endmodule

// File: tb/tb_axis_rr_arbiter.sv
// Self-checking bench for axis_rr_arbiter: vector table, directed corner sequences, randomized traffic.
module tb_axis_rr_arbiter;

  localparam int NI = 4;
  localparam int DW = 8;
  localparam int IW = 2;
  localparam int QD = 64;

  logic            aclk = 1'b0;
  logic            aresetn;
  logic [NI*DW-1:0] s_tdata;
  logic [NI-1:0]   s_tvalid;
  logic [NI-1:0]   s_tlast;
  logic [NI-1:0]   s_tready;
  logic [DW-1:0]   m_tdata;
  logic            m_tvalid;
  logic            m_tlast;
  logic [IW-1:0]   m_tid;
  logic            m_tready;

  int n_vec = 0;
  int n_err = 0;

  axis_rr_arbiter #(
    .NUM_INPUTS  (NI),
    .TDATA_BYTES (1)
  ) dut (
    .aclk     (aclk),
    .aresetn  (aresetn),
    .s_tdata  (s_tdata),
    .s_tvalid (s_tvalid),
    .s_tlast  (s_tlast),
    .s_tready (s_tready),
    .m_tdata  (m_tdata),
    .m_tvalid (m_tvalid),
    .m_tlast  (m_tlast),
    .m_tid    (m_tid),
    .m_tready (m_tready)
  );

  always #5 aclk = ~aclk;

  typedef struct {
    logic [NI-1:0]    vld;
    logic [NI-1:0]    lst;
    logic [NI*DW-1:0] dat;
    logic             mrdy;
    logic [NI-1:0]    e_srdy;
    logic             e_mv;
    logic [DW-1:0]    e_d;
    logic             e_l;
    logic [IW-1:0]    e_id;
  } vec_t;

  typedef struct packed {
    logic [DW-1:0] data;
    logic          last;
  } beat_t;

  typedef struct packed {
    logic [DW-1:0] data;
    logic          last;
    logic [IW-1:0] id;
  } obeat_t;

  beat_t  drv_mem  [NI][QD];
  int     drv_head [NI];
  int     drv_tail [NI];
  bit     mid      [NI];
  obeat_t exp_q    [$];
  int     model_last;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  task automatic set_in(input int i, input logic v, input logic [DW-1:0] d, input logic l);
    s_tvalid[i]         = v;
    s_tdata[i*DW +: DW] = d;
    s_tlast[i]          = l;
  endtask

  task automatic do_reset();
    aresetn  = 1'b0;
    s_tvalid = '0;
    s_tlast  = '0;
    s_tdata  = '0;
    m_tready = 1'b0;
    repeat (2) tick();
    aresetn    = 1'b1;
    model_last = NI - 1;
  endtask

  task automatic check_out(input string tag, input logic [DW-1:0] d, input logic l, input logic [IW-1:0] id);
    check({tag, " m_tvalid"}, m_tvalid, 1'b1);
    check({tag, " m_tdata"},  m_tdata,  d);
    check({tag, " m_tlast"},  m_tlast,  l);
    check({tag, " m_tid"},    m_tid,    id);
  endtask

  task automatic clear_traffic();
    for (int i = 0; i < NI; i++) begin
      drv_head[i] = 0;
      drv_tail[i] = 0;
      mid[i]      = 1'b0;
    end
    exp_q.delete();
  endtask

  task automatic push_packet(input int i, input int len, input bit rnd, input logic [DW-1:0] base);
    beat_t b;
    for (int k = 0; k < len; k++) begin
      b.data = rnd ? DW'($urandom) : base + DW'(k);
      b.last = (k == len - 1);
      drv_mem[i][drv_tail[i]] = b;
      drv_tail[i]++;
    end
  endtask

  // Reference: every input with queued packets is always requesting between packets, so the
  // delivered order is whole packets taken round-robin from the queues, starting after model_last.
  task automatic build_expected();
    int     h [NI];
    bit     found;
    int     j;
    obeat_t ob;
    for (int i = 0; i < NI; i++) h[i] = drv_head[i];
    found = 1'b1;
    while (found) begin
      found = 1'b0;
      for (int k = 1; k <= NI; k++) begin
        j = (model_last + k) % NI;
        if (!found && h[j] < drv_tail[j]) begin
          found = 1'b1;
          do begin
            ob.data = drv_mem[j][h[j]].data;
            ob.last = drv_mem[j][h[j]].last;
            ob.id   = IW'(j);
            exp_q.push_back(ob);
            h[j]++;
          end while (!ob.last);
          model_last = j;
        end
      end
    end
  endtask

  task automatic run_traffic(input int budget, input int rdy_pct);
    int     cyc;
    bit     hs [NI];
    obeat_t e;
    cyc = 0;
    while (exp_q.size() > 0 && cyc < budget) begin
      for (int i = 0; i < NI; i++) begin
        if (drv_head[i] < drv_tail[i]) begin
          set_in(i, mid[i] ? ($urandom_range(99) < 70) : 1'b1,
                 drv_mem[i][drv_head[i]].data, drv_mem[i][drv_head[i]].last);
        end else begin
          set_in(i, 1'b0, '0, 1'b0);
        end
      end
      m_tready = ($urandom_range(99) < rdy_pct);
      #1;
      check("rand s_tready onehot0", 32'($onehot0(s_tready)), 32'd1);
      for (int i = 0; i < NI; i++) hs[i] = s_tvalid[i] && s_tready[i];
      if (m_tvalid && m_tready) begin
        e = exp_q.pop_front();
        check("rand m_tdata", m_tdata, e.data);
        check("rand m_tlast", m_tlast, e.last);
        check("rand m_tid",   m_tid,   e.id);
      end
      tick();
      for (int i = 0; i < NI; i++) begin
        if (hs[i]) begin
          mid[i] = !drv_mem[i][drv_head[i]].last;
          drv_head[i]++;
        end
      end
      cyc++;
    end
    check("rand beats outstanding", exp_q.size(), 0);
    s_tvalid = '0;
    m_tready = 1'b1;
    #1;
    check("rand no extra beat", m_tvalid, 1'b0);
    tick();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t             tbl [14];
    logic [NI*DW-1:0] d0;
    logic [NI*DW-1:0] d1;
    logic [NI-1:0]    pend;
    logic [NI-1:0]    exp_rdy;

    aresetn  = 1'b1;
    s_tvalid = '0;
    s_tlast  = '0;
    s_tdata  = '0;
    m_tready = 1'b0;
    model_last = NI - 1;

    // Reset values, asserted between clock edges.
    #2;
    aresetn = 1'b0;
    #1;
    check("reset m_tvalid", m_tvalid, 1'b0);
    check("reset m_tdata",  m_tdata,  '0);
    check("reset m_tlast",  m_tlast,  1'b0);
    check("reset m_tid",    m_tid,    '0);
    check("reset s_tready", s_tready, '0);
    repeat (2) tick();
    aresetn  = 1'b1;
    m_tready = 1'b1;

    for (int c = 0; c < 10; c++) begin
      #1;
      check($sformatf("idle c%0d m_tvalid", c), m_tvalid, 1'b0);
      check($sformatf("idle c%0d s_tready", c), s_tready, '0);
      check($sformatf("idle c%0d m_tid", c),    m_tid,    '0);
      tick();
    end

    // Round-robin table: every input holds one 2-beat packet, data 8'h10*i+beat.
    for (int j = 0; j < NI; j++) d0[j*DW +: DW] = DW'(16 * j);
    for (int i = 0; i < NI; i++) begin
      pend = NI'(4'hF << i);
      d1 = d0;
      d1[i*DW +: DW] = DW'(16 * i + 1);
      tbl[3*i]   = '{vld: pend, lst: '0, dat: d0, mrdy: 1'b1, e_srdy: '0, e_mv: (i > 0),
                     e_d: (i > 0) ? DW'(16 * (i - 1) + 1) : '0, e_l: 1'b1,
                     e_id: (i > 0) ? IW'(i - 1) : '0};
      tbl[3*i+1] = '{vld: pend, lst: '0, dat: d0, mrdy: 1'b1, e_srdy: NI'(1 << i), e_mv: 1'b0,
                     e_d: '0, e_l: 1'b0, e_id: '0};
      tbl[3*i+2] = '{vld: pend, lst: NI'(1 << i), dat: d1, mrdy: 1'b1, e_srdy: NI'(1 << i),
                     e_mv: 1'b1, e_d: DW'(16 * i), e_l: 1'b0, e_id: IW'(i)};
    end
    tbl[12] = '{vld: '0, lst: '0, dat: '0, mrdy: 1'b1, e_srdy: '0, e_mv: 1'b1,
                e_d: 8'h31, e_l: 1'b1, e_id: IW'(3)};
    tbl[13] = '{vld: '0, lst: '0, dat: '0, mrdy: 1'b1, e_srdy: '0, e_mv: 1'b0,
                e_d: '0, e_l: 1'b0, e_id: '0};

    do_reset();
    for (int k = 0; k < 14; k++) begin
      s_tvalid = tbl[k].vld;
      s_tlast  = tbl[k].lst;
      s_tdata  = tbl[k].dat;
      m_tready = tbl[k].mrdy;
      #1;
      check($sformatf("rr v%0d s_tready", k), s_tready, tbl[k].e_srdy);
      check($sformatf("rr v%0d m_tvalid", k), m_tvalid, tbl[k].e_mv);
      if (tbl[k].e_mv) begin
        check($sformatf("rr v%0d m_tdata", k), m_tdata, tbl[k].e_d);
        check($sformatf("rr v%0d m_tlast", k), m_tlast, tbl[k].e_l);
        check($sformatf("rr v%0d m_tid", k),   m_tid,   tbl[k].e_id);
      end
      tick();
    end

    // Grant lock: input 2 pauses mid-packet while input 3 keeps requesting.
    do_reset();
    m_tready = 1'b1;
    for (int c = 0; c <= 10; c++) begin
      set_in(3, c <= 9, 8'h33, 1'b1);
      if (c <= 1)       set_in(2, 1'b1, 8'h20, 1'b0);
      else if (c == 6)  set_in(2, 1'b1, 8'h21, 1'b0);
      else if (c == 7)  set_in(2, 1'b1, 8'h22, 1'b1);
      else              set_in(2, 1'b0, 8'h00, 1'b0);
      exp_rdy = (c >= 1 && c <= 7) ? 4'b0100 : (c == 9) ? 4'b1000 : 4'b0000;
      #1;
      check($sformatf("lock c%0d s_tready", c), s_tready, exp_rdy);
      if (c == 2)  check_out("lock beat0", 8'h20, 1'b0, IW'(2));
      if (c == 8)  check_out("lock beat2", 8'h22, 1'b1, IW'(2));
      if (c == 10) check_out("lock in3",   8'h33, 1'b1, IW'(3));
      tick();
    end

    // Backpressure: hold 8'hA5 for 5 stalled cycles, then drain without loss or duplication.
    do_reset();
    for (int c = 0; c <= 9; c++) begin
      if (c <= 1)      set_in(1, 1'b1, 8'hA5, 1'b0);
      else if (c <= 7) set_in(1, 1'b1, 8'h5A, 1'b1);
      else             set_in(1, 1'b0, 8'h00, 1'b0);
      m_tready = !(c >= 2 && c <= 6);
      exp_rdy  = (c == 1 || c == 7) ? 4'b0010 : 4'b0000;
      #1;
      check($sformatf("bp c%0d s_tready", c), s_tready, exp_rdy);
      if (c >= 2 && c <= 7) check_out($sformatf("bp c%0d", c), 8'hA5, 1'b0, IW'(1));
      if (c == 8) check_out("bp tail", 8'h5A, 1'b1, IW'(1));
      if (c == 9) check("bp drained m_tvalid", m_tvalid, 1'b0);
      tick();
    end

    // Wrap-around: after a packet from input 3, inputs 0 and 3 request together.
    do_reset();
    m_tready = 1'b1;
    for (int c = 0; c <= 6; c++) begin
      set_in(0, c == 2 || c == 3, 8'h0C, 1'b1);
      if (c <= 1)      set_in(3, 1'b1, 8'h3C, 1'b1);
      else if (c <= 5) set_in(3, 1'b1, 8'h3D, 1'b1);
      else             set_in(3, 1'b0, 8'h00, 1'b0);
      case (c)
        1, 5:    exp_rdy = 4'b1000;
        3:       exp_rdy = 4'b0001;
        default: exp_rdy = 4'b0000;
      endcase
      #1;
      check($sformatf("wrap c%0d s_tready", c), s_tready, exp_rdy);
      if (c == 2) check_out("wrap first", 8'h3C, 1'b1, IW'(3));
      if (c == 4) check_out("wrap in0",   8'h0C, 1'b1, IW'(0));
      if (c == 6) check_out("wrap in3",   8'h3D, 1'b1, IW'(3));
      tick();
    end

    // Reset mid-packet: m_tvalid must fall with aresetn, not at the next edge.
    do_reset();
    m_tready = 1'b1;
    for (int c = 0; c <= 3; c++) begin
      set_in(1, 1'b1, (c <= 1) ? 8'hB0 : DW'(8'hB0 + c - 1), 1'b0);
      #1;
      if (c == 1) check("rst-mid grant s_tready", s_tready, 4'b0010);
      if (c < 3) tick();
    end
    check_out("rst-mid before", 8'hB1, 1'b0, IW'(1));
    #2;
    aresetn = 1'b0;
    #1;
    check("rst-mid async m_tvalid", m_tvalid, 1'b0);
    check("rst-mid async s_tready", s_tready, '0);
    check("rst-mid async m_tdata",  m_tdata,  '0);
    check("rst-mid async m_tid",    m_tid,    '0);
    tick();
    do_reset();
    clear_traffic();
    push_packet(0, 1, 1'b0, 8'h0F);
    push_packet(1, 4, 1'b0, 8'hC0);
    build_expected();
    run_traffic(200, 100);

    // Randomized traffic with random backpressure and mid-packet tvalid gaps.
    for (int r = 0; r < 8; r++) begin
      clear_traffic();
      for (int i = 0; i < NI; i++) begin
        for (int p = $urandom_range(3); p > 0; p--) push_packet(i, $urandom_range(4, 1), 1'b1, '0);
      end
      build_expected();
      run_traffic(2000, (r == 0) ? 100 : 30 + 10 * r);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
